// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between byte producers
// Optional packet lock keeps ownership until the owner's last byte or an idle timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA         = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                    i_divided_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*DATA-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]      i_req_last,
    output logic [NUM_REQ-1:0]      o_req_ack,
    output logic [DATA-1:0]         o_tx_data,
    output logic                    o_tx_ready,
    input  logic                    i_tx_next,
    output logic [NUM_REQ-1:0]      o_grant,
    output logic                    o_locked
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int CNT_LIM = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {S_ARB, S_LOAD, S_WAIT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W:0]     scan_sum;
    logic               scan_found;
    logic               owner_valid;
    logic               pick_go;
    logic               lock_idle;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] pick_oh;
    logic [CNT_W-1:0]   idle_cnt;

    // Scan from rr_ptr upward with an explicit wrap so any NUM_REQ works.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(NUM_REQ))
                scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
            if (!scan_found && i_req_valid[scan_sum[PTR_W-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = scan_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        owner_valid = i_req_valid[owner];
        pick_idx    = o_locked ? owner : scan_idx;
        pick_go     = (state == S_ARB) && i_tx_next && (o_locked ? owner_valid : scan_found);
        lock_idle   = (state == S_ARB) && i_tx_next && o_locked && !owner_valid
                      && (LOCK_TIMEOUT != 0);
        timeout_hit = lock_idle && (idle_cnt == CNT_W'(CNT_LIM));
        pick_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
    end

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_ARB;
        else if (i_en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ARB:   if (pick_go)    state_nxt = S_LOAD;
            S_LOAD:  if (!i_tx_next) state_nxt = S_WAIT;
            S_WAIT:  if (i_tx_next)  state_nxt = S_ARB;
            default:                 state_nxt = S_ARB;
        endcase
    end

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            o_req_ack  <= '0;
            o_tx_data  <= '0;
            o_tx_ready <= 1'b0;
            o_grant    <= '0;
            o_locked   <= 1'b0;
            rr_ptr     <= '0;
            owner      <= '0;
            idle_cnt   <= '0;
        end else if (i_en) begin
            o_req_ack <= '0;
            // A pick beats an expiring timeout when the owner returns on that edge.
            if (pick_go) begin
                o_tx_data  <= i_req_data[pick_idx*DATA +: DATA];
                o_tx_ready <= 1'b1;
                o_grant    <= pick_oh;
                o_req_ack  <= pick_oh;
                o_locked   <= !i_req_last[pick_idx];
                owner      <= pick_idx;
                rr_ptr     <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                idle_cnt   <= '0;
            end else if (timeout_hit) begin
                o_locked <= 1'b0;
                o_grant  <= '0;
                idle_cnt <= '0;
            end else if (lock_idle) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (state == S_LOAD && !i_tx_next)
                o_tx_ready <= 1'b0;
            if (state == S_WAIT && i_tx_next && !o_locked)
                o_grant <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a uart_tx model
// Directed scenarios followed by randomized packets checked against a transaction-level model.
module tb_uart_tx_arbiter;

    localparam int NR    = 2;
    localparam int DW    = 8;
    localparam int LT    = 16;
    localparam int FRAME = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0] req_last = '0;
    logic [NR-1:0] ack;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          tx_next = 1'b1;
    logic [NR-1:0] grant;
    logic          locked;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA(DW), .LOCK_TIMEOUT(LT)) dut (
        .i_divided_clk(clk),
        .i_rst(rst),
        .i_en(en),
        .i_req_valid(req_valid),
        .i_req_data(req_data),
        .i_req_last(req_last),
        .o_req_ack(ack),
        .o_tx_data(tx_data),
        .o_tx_ready(tx_ready),
        .i_tx_next(tx_next),
        .o_grant(grant),
        .o_locked(locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [8:0] qmem [0:1][0:127];
    int         qh [2];
    int         qt [2];
    int         ack_cnt [2];
    logic [7:0] log_d [0:255];
    logic [1:0] log_g [0:255];
    logic       log_l [0:255];
    int         log_n = 0;
    logic [7:0] exp_d [0:255];
    logic [1:0] exp_g [0:255];
    int         exp_n = 0;
    bit         tx_busy = 0;
    int         frame_left = 0;
    bit         rand_frame = 0;
    bit         rand_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic last);
        qmem[k][qt[k]] = {last, d};
        qt[k]++;
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < NR; k++) begin
            req_valid[k]         = (qh[k] != qt[k]);
            req_data[k*DW +: DW] = req_valid[k] ? qmem[k][qh[k]][7:0] : 8'h00;
            req_last[k]          = req_valid[k] ? qmem[k][qh[k]][8] : 1'b0;
        end
    endtask

    // One clock: sample DUT before the edge, then advance requesters and the uart_tx model.
    task automatic tick();
        logic       s_en, s_rdy, s_l;
        logic [7:0] s_d;
        logic [1:0] s_g, s_a;
        @(negedge clk);
        s_en = en; s_rdy = tx_ready; s_d = tx_data; s_g = grant; s_a = ack; s_l = locked;
        @(posedge clk);
        #1;
        if (s_en && !rst) begin
            for (int k = 0; k < NR; k++)
                if (s_a[k]) begin
                    ack_cnt[k]++;
                    if (qh[k] != qt[k]) qh[k]++;
                end
            if (tx_busy) begin
                if (frame_left <= 1) begin
                    tx_busy = 0;
                    tx_next = 1'b1;
                end else begin
                    frame_left--;
                end
            end else if (s_rdy) begin
                log_d[log_n] = s_d;
                log_g[log_n] = s_g;
                log_l[log_n] = s_l;
                log_n++;
                tx_busy    = 1;
                tx_next    = 1'b0;
                frame_left = rand_frame ? int'($urandom_range(2, 8)) : FRAME;
            end
        end
        drive_reqs();
        if (rand_en) en = ($urandom_range(0, 4) != 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_log(input int n, input int budget, input string tag);
        int c = 0;
        while (log_n < n && c < budget) begin
            tick();
            c++;
        end
        chk(tag, (c < budget), 1);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        tx_busy = 0;
        tx_next = 1'b1;
        log_n   = 0;
        for (int k = 0; k < NR; k++) begin
            qh[k] = 0; qt[k] = 0; ack_cnt[k] = 0;
        end
        drive_reqs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Byte order from the arbitration rules alone: round robin, lock held until last.
    task automatic build_expected();
        int  ptr = 0, own = 0, k;
        bit  lk = 0;
        int  h [2];
        exp_n = 0;
        h[0] = qh[0];
        h[1] = qh[1];
        while (h[0] != qt[0] || h[1] != qt[1]) begin
            if (lk && h[own] == qt[own]) lk = 0;
            if (lk) begin
                k = own;
            end else begin
                k = -1;
                for (int i = 0; i < NR; i++) begin
                    int c = (ptr + i) % NR;
                    if (k < 0 && h[c] != qt[c]) k = c;
                end
            end
            exp_d[exp_n] = qmem[k][h[k]][7:0];
            exp_g[exp_n] = (k == 0) ? 2'b01 : 2'b10;
            lk  = !qmem[k][h[k]][8];
            own = k;
            ptr = (k + 1) % NR;
            h[k]++;
            exp_n++;
        end
    endtask

    initial begin
        do_reset();
        chk("rst_ready", tx_ready, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_locked", locked, 0);

        // 1: single request
        push(0, 8'h55, 1'b1);
        drive_reqs();
        tick();
        chk("t1_ack", ack, 2'b01);
        chk("t1_ready", tx_ready, 1);
        chk("t1_data", tx_data, 8'h55);
        chk("t1_grant", grant, 2'b01);
        chk("t1_locked", locked, 0);
        tick();
        chk("t1_ack_clr", ack, 2'b00);
        chk("t1_ready_hold", tx_ready, 1);
        tick();
        chk("t1_ready_drop", tx_ready, 0);
        chk("t1_grant_wait", grant, 2'b01);
        run(FRAME + 4);
        chk("t1_grant_end", grant, 2'b00);
        chk("t1_log_n", log_n, 1);
        chk("t1_log_d", log_d[0], 8'h55);
        chk("t1_ack_cnt", ack_cnt[0], 1);

        // 2: contention
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 8'(8'h01 + i), 1'b1);
            push(1, 8'(8'h11 + i), 1'b1);
        end
        drive_reqs();
        run_until_log(8, 200, "t2_timeout");
        for (int i = 0; i < 8; i++) begin
            chk("t2_data", log_d[i], (i % 2 == 0) ? 8'(8'h01 + i / 2) : 8'(8'h11 + i / 2));
            chk("t2_grant", log_g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        chk("t2_ack0", ack_cnt[0], 4);
        chk("t2_ack1", ack_cnt[1], 4);

        // 3: packet lock
        do_reset();
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b0);
        push(0, 8'hA3, 1'b1);
        push(1, 8'hB1, 1'b1);
        drive_reqs();
        run_until_log(4, 200, "t3_timeout");
        chk("t3_d0", log_d[0], 8'hA1);
        chk("t3_d1", log_d[1], 8'hA2);
        chk("t3_d2", log_d[2], 8'hA3);
        chk("t3_d3", log_d[3], 8'hB1);
        chk("t3_g3", log_g[3], 2'b10);
        chk("t3_l0", log_l[0], 1);
        chk("t3_l1", log_l[1], 1);
        chk("t3_l2", log_l[2], 0);
        chk("t3_l3", log_l[3], 0);

        // 4: lock timeout
        do_reset();
        push(0, 8'h10, 1'b0);
        push(1, 8'h20, 1'b1);
        drive_reqs();
        run_until_log(1, 50, "t4_first");
        begin
            int c = 0;
            while (tx_busy && c < 50) begin
                tick();
                c++;
            end
            chk("t4_frame", (c < 50), 1);
        end
        for (int n = 1; n <= LT; n++) begin
            tick();
            chk("t4_still_locked", locked, 1);
        end
        tick();
        chk("t4_unlocked", locked, 0);
        chk("t4_grant_clr", grant, 2'b00);
        tick();
        chk("t4_grant1", grant, 2'b10);
        chk("t4_ack1", ack, 2'b10);
        chk("t4_data", tx_data, 8'h20);

        // 5: enable gating in S_LOAD
        do_reset();
        push(1, 8'h5A, 1'b1);
        drive_reqs();
        tick();
        chk("t5_pick", grant, 2'b10);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_ready", tx_ready, 1);
            chk("t5_data", tx_data, 8'h5A);
            chk("t5_grant", grant, 2'b10);
            chk("t5_ack", ack, 2'b10);
        end
        en = 1'b1;
        run_until_log(1, 20, "t5_timeout");
        run(FRAME + 10);
        chk("t5_log_n", log_n, 1);
        chk("t5_log_d", log_d[0], 8'h5A);
        chk("t5_ack_cnt", ack_cnt[1], 1);

        // 6: reset mid-frame
        do_reset();
        push(0, 8'h77, 1'b1);
        drive_reqs();
        run(3);
        chk("t6_in_wait", tx_ready, 0);
        chk("t6_sent", log_n, 1);
        rst = 1'b1;
        #1;
        chk("t6_grant", grant, 0);
        chk("t6_data", tx_data, 0);
        chk("t6_ack", ack, 0);
        chk("t6_locked", locked, 0);
        do_reset();
        push(1, 8'h88, 1'b1);
        drive_reqs();
        run_until_log(1, 60, "t6_timeout");
        run(FRAME + 10);
        chk("t6_log_n", log_n, 1);
        chk("t6_log_d", log_d[0], 8'h88);
        chk("t6_log_g", log_g[0], 2'b10);

        // Randomized packets, random frame lengths and enable
        do_reset();
        for (int k = 0; k < NR; k++) begin
            int npk = $urandom_range(3, 8);
            for (int p = 0; p < npk; p++) begin
                int len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++)
                    push(k, 8'($urandom), (b == len - 1));
            end
        end
        build_expected();
        drive_reqs();
        rand_frame = 1;
        rand_en    = 1;
        run_until_log(exp_n, 6000, "rnd_timeout");
        rand_en = 0;
        en      = 1'b1;
        run(20);
        chk("rnd_count", log_n, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            chk("rnd_data", log_d[i], exp_d[i]);
            chk("rnd_grant", log_g[i], exp_g[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
